frame_mem_arbiter: RTL and testbench

Two-requester arbiter in front of the single-port on-chip frame memory (8-bit wide, 400000 words, 19-bit address, 1-cycle read latency). Port 0 is the read-only video scan-out fetcher and has priority. Port 1 is the host/sprite read-write port, protected from starvation by a wait counter. The block drives the memory's chipselect/write/address/writedata and routes readdata back to the port that issued the read.

---
 rtl/frame_mem_arbiter.sv | 83 ++++++++
 tb/tb_frame_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mem_arbiter.sv
// Arbiter in front of the single-port frame memory: the video fetcher (port 0) has priority,
// and the host/sprite port (port 1) is forced a slot after MAX_WAIT consecutive denials.
module frame_mem_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 400000,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  WAIT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(MEM_DEPTH);

    logic              req0;
    logic              req1;
    logic              grant0;
    logic              grant1;
    logic              in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [CNT_W-1:0]  wait_cnt;
    logic              rd_pend0;
    logic              rd_pend1;
    logic              oor_q;

    assign req0 = m0_read;
    assign req1 = m1_read | m1_write;

    assign grant1 = ~reset & req1 & (~req0 | (wait_cnt == WAIT_MAX));
    assign grant0 = ~reset & req0 & ~grant1;

    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    assign sel_addr = grant1 ? m1_address : m0_address;
    assign in_range = ({1'b0, sel_addr} < DEPTH);

    assign mem_address    = sel_addr;
    assign mem_chipselect = (grant0 | grant1) & in_range;
    assign mem_write      = grant1 & m1_write & in_range;
    assign mem_writedata  = m1_writedata;

    // An out-of-range read was never issued to memory, so its return slot is forced to zero.
    assign m0_readdata      = oor_q ? '0 : mem_readdata;
    assign m1_readdata      = oor_q ? '0 : mem_readdata;
    assign m0_readdatavalid = rd_pend0;
    assign m1_readdatavalid = rd_pend1;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
            oor_q    <= 1'b0;
        end else begin
            if (~req1 | grant1)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + CNT_W'(1);
            rd_pend0 <= grant0;
            rd_pend1 <= grant1 & m1_read & ~m1_write;
            oor_q    <= (grant0 | grant1) & ~in_range;
        end
    end
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Bench for frame_mem_arbiter: behavioural memory, cycle-level reference model of the
// arbitration rules, directed scenarios and randomized masters obeying the hold protocol.
module tb_frame_mem_arbiter;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 400000;
    localparam int MAX_WAIT  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;
    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata = '0;

    frame_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // Frame memory: synchronous, one-cycle read latency.
    logic [DATA_W-1:0] mem_arr [0:MEM_DEPTH-1];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) mem_arr[mem_address] <= mem_writedata;
            else           mem_readdata <= mem_arr[mem_address];
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:MEM_DEPTH-1];
    int                denied;
    bit                exp_v0, exp_v1;
    logic [DATA_W-1:0] exp_d;
    bit                last_g0, last_g1;
    bit                obs_v0, obs_v1, obs_wr0, obs_wr1, obs_cs;
    logic [DATA_W-1:0] obs_d0, obs_d1;
    int                n_cmp, n_err;

    // One clock cycle: compare DUT against the model at the negedge, then advance the model.
    task automatic cyc();
        bit req0, req1, g0, g1, inr;
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        req0 = m0_read;
        req1 = m1_read | m1_write;
        g1 = !reset && req1 && (!req0 || denied >= MAX_WAIT);
        g0 = !reset && req0 && !g1;
        a = g1 ? m1_address : m0_address;
        inr = (g0 || g1) && (int'(a) < MEM_DEPTH);
        obs_v0 = m0_readdatavalid; obs_v1 = m1_readdatavalid;
        obs_d0 = m0_readdata; obs_d1 = m1_readdata;
        obs_wr0 = m0_waitrequest; obs_wr1 = m1_waitrequest; obs_cs = mem_chipselect;
        n_cmp++;
        if (m0_waitrequest !== (req0 && !g0)) begin
            n_err++; $display("FAIL m0_waitrequest got %0b want %0b t=%0t", m0_waitrequest, req0 && !g0, $time);
        end
        n_cmp++;
        if (m1_waitrequest !== (req1 && !g1)) begin
            n_err++; $display("FAIL m1_waitrequest got %0b want %0b t=%0t", m1_waitrequest, req1 && !g1, $time);
        end
        n_cmp++;
        if (mem_chipselect !== inr) begin
            n_err++; $display("FAIL mem_chipselect got %0b want %0b t=%0t", mem_chipselect, inr, $time);
        end
        n_cmp++;
        if (mem_write !== (g1 && m1_write && inr)) begin
            n_err++; $display("FAIL mem_write got %0b want %0b t=%0t", mem_write, g1 && m1_write && inr, $time);
        end
        if (inr) begin
            n_cmp++;
            if (mem_address !== a) begin
                n_err++; $display("FAIL mem_address got %h want %h t=%0t", mem_address, a, $time);
            end
            if (g1 && m1_write) begin
                n_cmp++;
                if (mem_writedata !== m1_writedata) begin
                    n_err++; $display("FAIL mem_writedata got %h want %h t=%0t", mem_writedata, m1_writedata, $time);
                end
            end
        end
        n_cmp++;
        if (m0_readdatavalid !== exp_v0) begin
            n_err++; $display("FAIL m0_readdatavalid got %0b want %0b t=%0t", m0_readdatavalid, exp_v0, $time);
        end
        n_cmp++;
        if (m1_readdatavalid !== exp_v1) begin
            n_err++; $display("FAIL m1_readdatavalid got %0b want %0b t=%0t", m1_readdatavalid, exp_v1, $time);
        end
        if (exp_v0) begin
            n_cmp++;
            if (m0_readdata !== exp_d) begin
                n_err++; $display("FAIL m0_readdata got %h want %h t=%0t", m0_readdata, exp_d, $time);
            end
        end
        if (exp_v1) begin
            n_cmp++;
            if (m1_readdata !== exp_d) begin
                n_err++; $display("FAIL m1_readdata got %h want %h t=%0t", m1_readdata, exp_d, $time);
            end
        end
        exp_v0 = g0;
        exp_v1 = g1 && m1_read && !m1_write;
        exp_d  = (exp_v0 || exp_v1) && inr ? ref_mem[a] : 8'h00;
        if (g1 && m1_write && inr) ref_mem[a] = m1_writedata;
        if (reset || !req1 || g1) denied = 0;
        else if (denied < MAX_WAIT) denied++;
        last_g0 = g0;
        last_g1 = g1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; m0_read = 1'b1; m0_address = 19'h00003;
        m1_read = 1'b0; m1_write = 1'b1; m1_address = 19'h00004; m1_writedata = 8'hEE;
        @(posedge clk); #1;
        repeat (2) begin
            cyc();
            n_cmp++;
            if (obs_cs !== 1'b0 || obs_wr0 !== 1'b1 || obs_wr1 !== 1'b1) begin
                n_err++; $display("FAIL reset_outputs cs=%0b wr0=%0b wr1=%0b want cs=0 wr0=1 wr1=1", obs_cs, obs_wr0, obs_wr1);
            end
        end
        idle();
        cyc();
        n_cmp++;
        if (obs_v0 !== 1'b0 || obs_v1 !== 1'b0) begin
            n_err++; $display("FAIL reset_valids v0=%0b v1=%0b want 0 0", obs_v0, obs_v1);
        end
    endtask

    task automatic test_port1_rw();
        int v0s;
        idle(); cyc();
        m1_write = 1'b1; m1_address = 19'h00010; m1_writedata = 8'hA5;
        cyc(); v0s = obs_v0;
        m1_write = 1'b0; m1_read = 1'b1;
        cyc(); v0s += obs_v0;
        n_cmp++;
        if (obs_wr1 !== 1'b0) begin
            n_err++; $display("FAIL p1_rw_wait got %0b want 0", obs_wr1);
        end
        m1_read = 1'b0;
        cyc(); v0s += obs_v0;
        n_cmp++;
        if (obs_v1 !== 1'b1 || obs_d1 !== 8'hA5) begin
            n_err++; $display("FAIL p1_rw_read valid=%0b data=%h want 1 a5", obs_v1, obs_d1);
        end
        n_cmp++;
        if (v0s != 0) begin
            n_err++; $display("FAIL p1_rw_m0valid count=%0d want 0", v0s);
        end
    endtask

    task automatic test_starvation();
        int v0s, v1s, stalls, stall_at;
        idle(); cyc(); cyc();
        v0s = 0; v1s = 0; stalls = 0; stall_at = -1;
        m0_read = 1'b1; m0_address = 19'h00100;
        m1_read = 1'b1; m1_address = 19'h00010;
        for (int i = 0; i < 20; i++) begin
            cyc();
            v0s += obs_v0; v1s += obs_v1;
            if (obs_wr0) begin stalls++; stall_at = i; end
            if (last_g0) m0_address = m0_address + 19'd1;
            if (last_g1) m1_read = 1'b0;
        end
        idle();
        cyc(); v0s += obs_v0; v1s += obs_v1;
        n_cmp++;
        if (stalls != 1 || stall_at != MAX_WAIT) begin
            n_err++; $display("FAIL starve_stall count=%0d at=%0d want 1 at %0d", stalls, stall_at, MAX_WAIT);
        end
        n_cmp++;
        if (v0s != 19 || v1s != 1) begin
            n_err++; $display("FAIL starve_valids m0=%0d m1=%0d want 19 1", v0s, v1s);
        end
    endtask

    task automatic test_simultaneous();
        idle(); cyc();
        m0_read = 1'b1; m0_address = 19'h00007;
        m1_read = 1'b1; m1_address = 19'h00008;
        cyc();
        n_cmp++;
        if (obs_wr0 !== 1'b0 || obs_wr1 !== 1'b1) begin
            n_err++; $display("FAIL simul_first wr0=%0b wr1=%0b want 0 1", obs_wr0, obs_wr1);
        end
        m0_read = 1'b0;
        cyc();
        n_cmp++;
        if (obs_wr1 !== 1'b0) begin
            n_err++; $display("FAIL simul_second wr1=%0b want 0", obs_wr1);
        end
        idle(); cyc();
    endtask

    task automatic test_out_of_range();
        bit cs_seen;
        idle(); cyc();
        m1_write = 1'b1; m1_address = 19'(MEM_DEPTH); m1_writedata = 8'h55;
        cyc(); cs_seen = obs_cs;
        m1_write = 1'b0; m1_read = 1'b1;
        cyc(); cs_seen |= obs_cs;
        m1_read = 1'b0;
        cyc();
        n_cmp++;
        if (cs_seen || obs_v1 !== 1'b1 || obs_d1 !== 8'h00) begin
            n_err++; $display("FAIL oor cs_seen=%0b valid=%0b data=%h want 0 1 00", cs_seen, obs_v1, obs_d1);
        end
    endtask

    task automatic test_read_write_both();
        idle(); cyc();
        m1_read = 1'b1; m1_write = 1'b1; m1_address = 19'h00005; m1_writedata = 8'h3C;
        cyc();
        m1_write = 1'b0;
        cyc();
        n_cmp++;
        if (obs_v1 !== 1'b0) begin
            n_err++; $display("FAIL rw_both_valid got %0b want 0", obs_v1);
        end
        m1_read = 1'b0;
        cyc();
        n_cmp++;
        if (obs_v1 !== 1'b1 || obs_d1 !== 8'h3C) begin
            n_err++; $display("FAIL rw_both_read valid=%0b data=%h want 1 3c", obs_v1, obs_d1);
        end
    endtask

    task automatic test_reset_mid();
        int v0s, first_g1;
        idle(); cyc();
        m0_read = 1'b1; m0_address = 19'h00020;
        m1_read = 1'b1; m1_address = 19'h00021;
        cyc();
        reset = 1'b1; m0_address = 19'h00022;
        cyc();
        cyc();
        n_cmp++;
        if (obs_v0 !== 1'b0 || obs_cs !== 1'b0) begin
            n_err++; $display("FAIL reset_mid valid=%0b cs=%0b want 0 0", obs_v0, obs_cs);
        end
        reset = 1'b0;
        v0s = 0; first_g1 = -1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (i == 0) v0s = obs_v0;
            if (last_g1 && first_g1 < 0) begin first_g1 = i; m1_read = 1'b0; end
            if (last_g0) m0_address = m0_address + 19'd1;
        end
        n_cmp++;
        if (v0s != 0) begin
            n_err++; $display("FAIL reset_mid_post valid=%0d want 0", v0s);
        end
        n_cmp++;
        if (first_g1 != MAX_WAIT) begin
            n_err++; $display("FAIL reset_mid_waitcnt m1 grant cycle=%0d want %0d", first_g1, MAX_WAIT);
        end
        idle(); cyc();
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return 19'(MEM_DEPTH - 2 + int'($urandom_range(0, 3)));
        return 19'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        idle(); cyc();
        for (int i = 0; i < 600; i++) begin
            if (!m0_read || last_g0) begin
                m0_read = ($urandom_range(0, 3) != 0);
                m0_address = rand_addr();
            end
            if (!(m1_read || m1_write) || last_g1) begin
                case ($urandom_range(0, 4))
                    0, 1:    begin m1_read = 1'b0; m1_write = 1'b0; end
                    2:       begin m1_read = 1'b1; m1_write = 1'b0; end
                    3:       begin m1_read = 1'b0; m1_write = 1'b1; end
                    default: begin m1_read = 1'b1; m1_write = 1'b1; end
                endcase
                m1_address = rand_addr();
                m1_writedata = 8'($urandom);
            end
            reset = ($urandom_range(0, 99) == 0);
            cyc();
        end
        idle(); cyc(); cyc();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; denied = 0;
        exp_v0 = 0; exp_v1 = 0; exp_d = '0; last_g0 = 0; last_g1 = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_arr[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        m0_address = '0; m1_address = '0; m1_writedata = '0;
        test_reset();
        test_port1_rw();
        test_starvation();
        test_simultaneous();
        test_out_of_range();
        test_read_write_both();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
